// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core.
//   DATA_W / RD_W : datapath width and register-index width
//   alu_op_t      : 3-bit ALU operation encoding
//   exe_state_t   : execute-stage multiplier occupancy state
package core_pkg;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } exe_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock.
//   clk, reset   : clock and synchronous active-high reset
//   start_i      : load operands and begin (ignored while busy)
//   a_i, b_i     : multiplicand / multiplier
//   busy_o       : an operation is in progress
//   done_o       : current cycle performs the final step
//   product_o    : low DATA_W bits of a*b, valid while done_o=1
module seq_multiplier
    import core_pkg::*;
#(
    parameter int DATA_W = core_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int CNT_W = $clog2(DATA_W);

    exe_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] step_acc;
    logic              last_step;

    // Accumulator value after the current step; on the last step this is
    // the finished product, so it is handed out before it is registered.
    assign step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (count_q == CNT_W'(DATA_W - 1));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = a_i;
                    mplier_d = b_i;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (last_step) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy_o    = (state_q == BUSY);
    assign done_o    = busy_o && last_step;
    assign product_o = step_acc;

endmodule

// File: rtl/exe_mem_stage.sv
// Execute stage and EXE/MEM pipeline register.
//   Inputs : PC, PC+2, operands, immediate, rd and control flags from ID/EXE
//   pc_target_out / pc_src_out / flush_out : branch/jump redirect (comb)
//   stall_out : hold upstream stages while a multiply is in flight (comb)
//   *_out registered : ALU/multiply result, store data, rd, PC+2, controls
module exe_mem_stage
    import core_pkg::*;
#(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int RD_W   = core_pkg::RD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] pc_plus2_in,
    input  logic [DATA_W-1:0] op1_in,
    input  logic [DATA_W-1:0] op2_in,
    input  logic [DATA_W-1:0] extend_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              regWrite_in,
    input  logic              memWrite_in,
    input  logic              jump_in,
    input  logic              branch_in,
    input  logic              aluSrc_in,
    input  logic [1:0]        resultSrc_in,
    input  logic [2:0]        aluControl_in,
    output logic [DATA_W-1:0] pc_target_out,
    output logic              pc_src_out,
    output logic              flush_out,
    output logic              stall_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [DATA_W-1:0] pc_plus2_out,
    output logic              regWrite_out,
    output logic              memWrite_out,
    output logic [1:0]        resultSrc_out
);

    logic [DATA_W-1:0]        src_b;
    logic signed [DATA_W-1:0] op1_s, src_b_s;
    logic [DATA_W-1:0]        alu_result;
    logic                     zero;
    logic                     is_mul;
    logic                     mul_busy, mul_done;
    logic [DATA_W-1:0]        mul_product;

    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] pc_plus2_q, pc_plus2_d;
    logic              regWrite_q, regWrite_d;
    logic              memWrite_q, memWrite_d;
    logic [1:0]        resultSrc_q, resultSrc_d;

    // ---------------- execute ----------------
    assign src_b   = aluSrc_in ? extend_in : op2_in;
    assign op1_s   = op1_in;
    assign src_b_s = src_b;

    always_comb begin
        alu_result = '0;
        unique case (alu_op_t'(aluControl_in))
            ALU_ADD: alu_result = op1_in + src_b;
            ALU_SUB: alu_result = op1_in - src_b;
            ALU_AND: alu_result = op1_in & src_b;
            ALU_OR:  alu_result = op1_in | src_b;
            ALU_XOR: alu_result = op1_in ^ src_b;
            ALU_SLT: alu_result = (op1_s < src_b_s) ? DATA_W'(1) : '0;
            ALU_SLL: alu_result = op1_in << src_b[3:0];
            // Real products come from the sequential unit; a MUL encoding
            // without regWrite is a bubble and carries no result.
            ALU_MUL: alu_result = '0;
            default: alu_result = '0;
        endcase
    end

    assign zero   = ((op1_in - src_b) == '0);
    assign is_mul = regWrite_in && (aluControl_in == ALU_MUL);

    // Redirects are suppressed while a multiply owns the stage: the
    // instruction in ID/EXE is frozen and must not be resolved twice.
    assign pc_target_out = pc_in + extend_in;
    assign pc_src_out    = !reset && !mul_busy && (jump_in || (branch_in && zero));
    assign flush_out     = pc_src_out;
    assign stall_out     = !reset && ((!mul_busy && is_mul) || (mul_busy && !mul_done));

    seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (is_mul && !mul_busy),
        .a_i       (op1_in),
        .b_i       (src_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // ---------------- EXE/MEM register ----------------
    always_comb begin
        alu_result_d = '0;
        write_data_d = '0;
        rd_d         = '0;
        pc_plus2_d   = '0;
        regWrite_d   = 1'b0;
        memWrite_d   = 1'b0;
        resultSrc_d  = '0;
        // A bubble is issued while a multiply is launching or iterating;
        // rd/controls are sampled from the held ID/EXE inputs on completion.
        if (mul_done || (!mul_busy && !is_mul)) begin
            alu_result_d = mul_done ? mul_product : alu_result;
            write_data_d = op2_in;
            rd_d         = rd_in;
            pc_plus2_d   = pc_plus2_in;
            regWrite_d   = regWrite_in;
            memWrite_d   = memWrite_in;
            resultSrc_d  = resultSrc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            pc_plus2_q   <= '0;
            regWrite_q   <= 1'b0;
            memWrite_q   <= 1'b0;
            resultSrc_q  <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            pc_plus2_q   <= pc_plus2_d;
            regWrite_q   <= regWrite_d;
            memWrite_q   <= memWrite_d;
            resultSrc_q  <= resultSrc_d;
        end
    end

    assign alu_result_out = alu_result_q;
    assign write_data_out = write_data_q;
    assign rd_out         = rd_q;
    assign pc_plus2_out   = pc_plus2_q;
    assign regWrite_out   = regWrite_q;
    assign memWrite_out   = memWrite_q;
    assign resultSrc_out  = resultSrc_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in, pc_plus2_in, op1_in, op2_in, extend_in;
    logic [3:0]  rd_in;
    logic        regWrite_in, memWrite_in, jump_in, branch_in, aluSrc_in;
    logic [1:0]  resultSrc_in;
    logic [2:0]  aluControl_in;
    logic [15:0] pc_target_out;
    logic        pc_src_out, flush_out, stall_out;
    logic [15:0] alu_result_out, write_data_out, pc_plus2_out;
    logic [3:0]  rd_out;
    logic        regWrite_out, memWrite_out;
    logic [1:0]  resultSrc_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_mem_stage dut (
        .clk(clk), .reset(reset),
        .pc_in(pc_in), .pc_plus2_in(pc_plus2_in),
        .op1_in(op1_in), .op2_in(op2_in), .extend_in(extend_in),
        .rd_in(rd_in), .regWrite_in(regWrite_in), .memWrite_in(memWrite_in),
        .jump_in(jump_in), .branch_in(branch_in), .aluSrc_in(aluSrc_in),
        .resultSrc_in(resultSrc_in), .aluControl_in(aluControl_in),
        .pc_target_out(pc_target_out), .pc_src_out(pc_src_out),
        .flush_out(flush_out), .stall_out(stall_out),
        .alu_result_out(alu_result_out), .write_data_out(write_data_out),
        .rd_out(rd_out), .pc_plus2_out(pc_plus2_out),
        .regWrite_out(regWrite_out), .memWrite_out(memWrite_out),
        .resultSrc_out(resultSrc_out)
    );

    // Reference: what the ALU/multiplier should produce, from plain arithmetic.
    function automatic logic [15:0] ref_result(input logic [2:0] op,
                                               input logic [15:0] a,
                                               input logic [15:0] b);
        logic [31:0] full;
        logic [3:0]  sh;
        full = 32'(a) * 32'(b);
        sh   = b[3:0];
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd6: return a << sh;
            default: return full[15:0];
        endcase
    endfunction

    function automatic logic [15:0] ref_srcb();
        return aluSrc_in ? extend_in : op2_in;
    endfunction

    // Packed view of every registered output, for whole-register comparisons.
    function automatic logic [56:0] out_bus();
        return {alu_result_out, write_data_out, rd_out, pc_plus2_out,
                regWrite_out, memWrite_out, resultSrc_out};
    endfunction

    function automatic logic [56:0] exp_capture(input logic [15:0] res);
        return {res, op2_in, rd_in, pc_plus2_in, regWrite_in, memWrite_in, resultSrc_in};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        pc_in = 0; pc_plus2_in = 0; op1_in = 0; op2_in = 0; extend_in = 0;
        rd_in = 0; regWrite_in = 0; memWrite_in = 0; jump_in = 0;
        branch_in = 0; aluSrc_in = 0; resultSrc_in = 0; aluControl_in = 0;
    endtask

    task automatic set_random(input logic [2:0] op);
        pc_in = 16'($urandom); pc_plus2_in = pc_in + 16'd2;
        op1_in = 16'($urandom); op2_in = 16'($urandom); extend_in = 16'($urandom);
        rd_in = 4'($urandom); regWrite_in = 1'($urandom); memWrite_in = 1'($urandom);
        jump_in = 0; branch_in = 0; aluSrc_in = 1'($urandom);
        resultSrc_in = 2'($urandom); aluControl_in = op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_random(3'd7);
        regWrite_in = 1; jump_in = 1; branch_in = 1;
        step();
        step();
        #1;
        checks++;
        if (out_bus() !== 57'd0) begin
            errors++; $display("FAIL reset_regs got %h exp 0", out_bus());
        end
        checks++;
        if ({pc_src_out, flush_out, stall_out} !== 3'b000) begin
            errors++; $display("FAIL reset_comb got %b exp 000", {pc_src_out, flush_out, stall_out});
        end
        checks++;
        if (pc_target_out !== 16'(pc_in + extend_in)) begin
            errors++; $display("FAIL reset_target got %h exp %h", pc_target_out, 16'(pc_in + extend_in));
        end
        set_nop();
        reset = 1'b0;
        step();
    endtask

    task automatic test_alu_random();
        logic [15:0] exp;
        for (int i = 0; i < 60; i++) begin
            set_random(3'($urandom_range(0, 6)));
            exp = ref_result(aluControl_in, op1_in, ref_srcb());
            #1;
            checks++;
            if (stall_out !== 1'b0) begin
                errors++; $display("FAIL alu_stall op %0d got %b exp 0", aluControl_in, stall_out);
            end
            step();
            checks++;
            if (out_bus() !== exp_capture(exp)) begin
                errors++; $display("FAIL alu_capture op %0d got %h exp %h", aluControl_in, out_bus(), exp_capture(exp));
            end
        end
    endtask

    task automatic test_alu_directed();
        set_nop();
        op1_in = 16'h0005; op2_in = 16'h0003; aluControl_in = 3'b000; regWrite_in = 1; rd_in = 4'd2;
        step();
        checks++;
        if ({alu_result_out, rd_out, regWrite_out, stall_out} !== {16'h0008, 4'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_5_3 got %h/%0d/%b/%b exp 0008/2/1/0", alu_result_out, rd_out, regWrite_out, stall_out);
        end
        op1_in = 16'hFFFF; extend_in = 16'h0001; aluSrc_in = 1; aluControl_in = 3'b101;
        step();
        checks++;
        if (alu_result_out !== 16'h0001) begin
            errors++; $display("FAIL slt_neg got %h exp 0001", alu_result_out);
        end
        aluControl_in = 3'b000;
        step();
        checks++;
        if (alu_result_out !== 16'h0000) begin
            errors++; $display("FAIL add_wrap got %h exp 0000", alu_result_out);
        end
    endtask

    task automatic test_branch();
        logic exp_src;
        set_nop();
        branch_in = 1; op1_in = 16'h1234; op2_in = 16'h1234; pc_in = 16'h0040; extend_in = 16'hFFF0;
        #1;
        checks++;
        if ({pc_src_out, flush_out, pc_target_out} !== {1'b1, 1'b1, 16'h0030}) begin
            errors++; $display("FAIL branch_taken got %b/%b/%h exp 1/1/0030", pc_src_out, flush_out, pc_target_out);
        end
        op2_in = 16'h1235;
        #1;
        checks++;
        if ({pc_src_out, flush_out} !== 2'b00) begin
            errors++; $display("FAIL branch_not_taken got %b/%b exp 0/0", pc_src_out, flush_out);
        end
        step();
        // Random jumps/branches: taken ones still write their link PC+2.
        for (int i = 0; i < 30; i++) begin
            set_random(3'($urandom_range(0, 1)));
            jump_in = 1'($urandom); branch_in = ~jump_in;
            if ($urandom_range(0, 1) == 1) op2_in = op1_in;
            aluSrc_in = 0;
            if (jump_in) begin regWrite_in = 1; resultSrc_in = 2'd2; end
            exp_src = jump_in | (branch_in & (op1_in == op2_in));
            #1;
            checks++;
            if ({pc_src_out, flush_out, pc_target_out} !== {exp_src, exp_src, 16'(pc_in + extend_in)}) begin
                errors++; $display("FAIL redirect got %b/%b/%h exp %b/%b/%h", pc_src_out, flush_out,
                                   pc_target_out, exp_src, exp_src, 16'(pc_in + extend_in));
            end
            step();
            checks++;
            if (out_bus() !== exp_capture(ref_result(aluControl_in, op1_in, op2_in))) begin
                errors++; $display("FAIL redirect_capture got %h exp %h", out_bus(),
                                   exp_capture(ref_result(aluControl_in, op1_in, op2_in)));
            end
        end
        set_nop();
        step();
    endtask

    // Launch a multiply and follow its 17-cycle occupancy, then issue an add
    // right behind it; the add must land on the 18th edge.
    task automatic test_mul(input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd);
        logic [15:0] exp;
        set_nop();
        op1_in = a; op2_in = b; rd_in = rd; regWrite_in = 1; aluControl_in = 3'b111;
        resultSrc_in = 2'd0; pc_plus2_in = 16'h0102;
        exp = ref_result(3'd7, a, b);
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++; $display("FAIL mul_stall_start got %b exp 1", stall_out);
        end
        for (int e = 1; e <= 16; e++) begin
            step();
            checks++;
            if ({stall_out, regWrite_out, pc_src_out} !== {(e < 16), 1'b0, 1'b0}) begin
                errors++; $display("FAIL mul_busy edge %0d stall/regWrite/pc_src got %b%b%b exp %b00",
                                   e, stall_out, regWrite_out, pc_src_out, (e < 16));
            end
        end
        step();
        checks++;
        if ({alu_result_out, rd_out, regWrite_out} !== {exp, rd, 1'b1}) begin
            errors++; $display("FAIL mul_result got %h/%0d/%b exp %h/%0d/1", alu_result_out, rd_out, regWrite_out, exp, rd);
        end
        set_random(3'd0);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL mul_after_stall got %b exp 0", stall_out);
        end
        step();
        checks++;
        if (out_bus() !== exp_capture(ref_result(3'd0, op1_in, ref_srcb()))) begin
            errors++; $display("FAIL mul_next_instr got %h exp %h", out_bus(),
                               exp_capture(ref_result(3'd0, op1_in, ref_srcb())));
        end
    endtask

    task automatic test_mul_directed();
        test_mul(16'h0123, 16'h0045, 4'd7);
        checks++;
        if (ref_result(3'd7, 16'h0123, 16'h0045) !== 16'h4E6F) begin
            errors++; $display("FAIL mul_ref_const got %h exp 4E6F", ref_result(3'd7, 16'h0123, 16'h0045));
        end
        test_mul(16'hFFFF, 16'hFFFF, 4'd3);
        for (int i = 0; i < 3; i++) test_mul(16'($urandom), 16'($urandom), 4'($urandom));
    endtask

    task automatic test_mul_bubble();
        set_nop();
        aluControl_in = 3'b111; op1_in = 16'h0077; op2_in = 16'h0011;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL bubble_stall got %b exp 0", stall_out);
        end
        step();
        checks++;
        if ({stall_out, regWrite_out, memWrite_out} !== 3'b000) begin
            errors++; $display("FAIL bubble_capture got %b exp 000", {stall_out, regWrite_out, memWrite_out});
        end
    endtask

    task automatic test_reset_busy();
        set_nop();
        op1_in = 16'h00F3; op2_in = 16'h0021; rd_in = 4'd9; regWrite_in = 1; aluControl_in = 3'b111;
        for (int e = 1; e <= 9; e++) step();   // count is now 8
        checks++;
        if (stall_out !== 1'b1) begin
            errors++; $display("FAIL busy8_stall got %b exp 1", stall_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL reset_busy_stall got %b exp 0", stall_out);
        end
        step();
        checks++;
        if ({out_bus(), stall_out} !== 58'd0) begin
            errors++; $display("FAIL reset_busy_regs got %h exp 0", {out_bus(), stall_out});
        end
        reset = 1'b0;
        set_nop();
        op1_in = 16'h1000; op2_in = 16'h0234; rd_in = 4'd5; regWrite_in = 1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL post_reset_stall got %b exp 0", stall_out);
        end
        step();
        checks++;
        if ({alu_result_out, rd_out, regWrite_out} !== {16'h1234, 4'd5, 1'b1}) begin
            errors++; $display("FAIL post_reset_add got %h/%0d/%b exp 1234/5/1", alu_result_out, rd_out, regWrite_out);
        end
        // Multiply launched straight after the abort still works.
        test_mul(16'h0031, 16'h0102, 4'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        set_nop();
        reset = 1'b1;
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_branch();
        test_mul_directed();
        test_mul_bubble();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
